// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-side signals of the instruction memory arbiter
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_lock, mem_rdata,
        output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin fetch/loader arbiter for a single-cycle imem port with bounded loader lock
module imem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_LOCK = 16
) (
    input logic           clk,
    input logic           rst_n,
    imem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    typedef enum logic {RR, LOCKED} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  lock_cnt, cnt_nxt;
    logic              last, last_nxt;
    logic              lk, brk, f_gnt, d_gnt;
    logic [ADDR_W-1:0] sel_addr;
    logic              f_rvalid, d_rvalid;
    logic [DATA_W-1:0] f_rdata, d_rdata;

    // grant decision and next arbitration state; a held lock wins unless fetch has waited MAX_LOCK cycles
    always_comb begin
        lk        = state == LOCKED && bus.d_req && bus.d_lock;
        brk       = lk && bus.f_req && lock_cnt == CNT_W'(MAX_LOCK);
        f_gnt     = rst_n && (lk ? brk : bus.f_req && (!bus.d_req || last));
        d_gnt     = rst_n && (lk ? !brk : bus.d_req && (!bus.f_req || !last));
        state_nxt = d_gnt && bus.d_lock ? LOCKED : RR;
        cnt_nxt   = lk && d_gnt ? lock_cnt + CNT_W'(bus.f_req) : '0;
        last_nxt  = f_gnt ? 1'b0 : d_gnt ? 1'b1 : last;
        sel_addr  = f_gnt ? bus.f_addr : d_gnt ? bus.d_addr : '0;
    end

    // arbitration state register; last resets to loader so fetch wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RR;
            lock_cnt <= '0;
            last     <= 1'b1;
        end else begin
            state    <= state_nxt;
            lock_cnt <= cnt_nxt;
            last     <= last_nxt;
        end
    end

    // read data captured at the grant edge; writes acknowledge with zero data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            f_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            f_rvalid <= f_gnt;
            d_rvalid <= d_gnt;
            if (f_gnt) f_rdata <= bus.mem_rdata;
            if (d_gnt) d_rdata <= bus.d_we ? '0 : bus.mem_rdata;
        end
    end

    assign bus.f_gnt     = f_gnt;
    assign bus.d_gnt     = d_gnt;
    assign bus.mem_addr  = sel_addr & ~ADDR_W'(3);
    assign bus.mem_we    = d_gnt && bus.d_we;
    assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    assign bus.f_rvalid  = f_rvalid;
    assign bus.d_rvalid  = d_rvalid;
    assign bus.f_rdata   = f_rdata;
    assign bus.d_rdata   = d_rdata;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random checks of imem_arbiter against a rule-level reference model
module tb_imem_arbiter;
    localparam int MAX_LOCK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_ok = 1'b0;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    int compared = 0;
    int mismatched = 0;

    int m_last;
    int m_streak;
    bit m_lock;
    logic e_frv, e_drv;
    logic [31:0] e_frd, e_drd;

    imem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    imem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return i == 2 ? 32'h00500093 : {16'(i * 7 + 1), 16'(~i)};
    endfunction

    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    always @(posedge clk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_ok <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = 2;
        m_lock = 0;
        m_streak = 0;
        e_frv = 0;
        e_drv = 0;
        e_frd = 0;
        e_drd = 0;
    endtask

    // one cycle: check last cycle's responses, drive requests, check grant and memory mux, advance model
    task automatic step(input logic fr, input logic [31:0] fa, input logic dr, input logic dw,
                        input logic [31:0] da, input logic [31:0] dwd, input logic dl, output int eg);
        logic [31:0] ea;
        @(negedge clk);
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(e_frv));
        chk("f_rdata", bus.f_rdata, e_frd);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(e_drv));
        chk("d_rdata", bus.d_rdata, e_drd);
        bus.f_req = fr;
        bus.f_addr = fa;
        bus.d_req = dr;
        bus.d_we = dw;
        bus.d_addr = da;
        bus.d_wdata = dwd;
        bus.d_lock = dl;
        #1;
        if (!rst_n) eg = 0;
        else if (m_lock && dr && dl) eg = (fr && m_streak == MAX_LOCK) ? 1 : 2;
        else if (fr && dr) eg = (m_last == 2) ? 1 : 2;
        else eg = fr ? 1 : (dr ? 2 : 0);
        ea = eg == 1 ? fa : (eg == 2 ? da : 32'h0);
        ea[1:0] = 2'b00;
        chk("f_gnt", 32'(bus.f_gnt), 32'(eg == 1));
        chk("d_gnt", 32'(bus.d_gnt), 32'(eg == 2));
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_we", 32'(bus.mem_we), 32'(eg == 2 && dw));
        chk("mem_wdata", bus.mem_wdata, eg == 2 ? dwd : 32'h0);
        e_frv = eg == 1;
        e_drv = eg == 2;
        if (eg == 1) e_frd = ref_mem[fa[7:2]];
        if (eg == 2) begin
            if (dw) begin
                e_drd = 32'h0;
                ref_mem[da[7:2]] = dwd;
            end else begin
                e_drd = ref_mem[da[7:2]];
            end
        end
        if (eg == 2 && dl) begin
            m_streak = m_lock ? m_streak + int'(fr) : 0;
            m_lock = 1;
        end else begin
            m_lock = 0;
            m_streak = 0;
        end
        if (eg != 0) m_last = eg;
    endtask

    initial begin
        int g;
        logic fp, dp, dw_r, dl_r;
        logic [31:0] fa_r, da_r, dwd_r;
        bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_lock = 0;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, g);
        // fetch of word 2
        step(1, 32'h8, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // loader read so the next tie goes to fetch, then 6 cycles of contention
        step(0, 0, 1, 0, 32'h20, 0, 0, g);
        for (int i = 0; i < 6; i++) step(1, 32'(4 * i), 1, 0, 32'(32'h40 + 4 * i), 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // write then misaligned read of the same word
        step(0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0, g);
        step(0, 0, 1, 0, 32'h13, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // loader burst lock against a waiting fetch until the lock breaks
        for (int i = 0; i < 8; i++) step(1, 32'h4, 1, 0, 32'(32'h80 + 4 * i), 0, 1, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // lock dropped mid-burst hands the port to fetch
        for (int i = 0; i < 3; i++) step(1, 32'hC, 1, 0, 32'(32'h90 + 4 * i), 0, 1, g);
        step(1, 32'hC, 1, 0, 32'h9C, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // reset right after a grant drops the response
        step(1, 32'h8, 0, 0, 0, 0, 0, g);
        rst_n = 1'b0;
        model_reset();
        step(1, 32'h8, 1, 0, 32'h24, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        rst_n = 1'b1;
        step(1, 32'h8, 1, 0, 32'h24, 0, 0, g);
        step(0, 0, 1, 0, 32'h24, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        // random traffic honouring the hold-until-granted contract
        fp = 0; dp = 0; fa_r = 0; da_r = 0; dwd_r = 0; dw_r = 0;
        for (int i = 0; i < 400; i++) begin
            if (!fp) begin
                fp = $urandom_range(0, 2) != 0;
                fa_r = $urandom_range(0, 255);
            end
            if (!dp) begin
                dp = $urandom_range(0, 2) != 0;
                dw_r = 1'($urandom_range(0, 1));
                da_r = $urandom_range(0, 255);
                dwd_r = $urandom;
            end
            dl_r = $urandom_range(0, 4) != 0;
            step(fp, fa_r, dp, dw_r, da_r, dwd_r, dl_r, g);
            if (g == 1) fp = 0;
            if (g == 2) dp = 0;
        end
        step(0, 0, 0, 0, 0, 0, 0, g);
        step(0, 0, 0, 0, 0, 0, 0, g);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
